wb_retire: RTL and testbench
============================

Name: wb_retire

Overview:
- In-order writeback/retire stage between the memory stage and the register file.
- Buffers completed instructions in a small queue and writes the register file through a ready handshake.
- Drives the per-instruction retire pulse W_v and the sticky isHalt consumed by the cycle/instruction counter.
- Provides youngest-pending-write forwarding to the decode/execute bypass network.

Parameters:
- DATA_W, 16, register data width
- REG_AW, 4, register index width (16 architectural registers)
- PC_W, 16, program counter width
- DEPTH, 4, retire queue entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- M_v  in  1  memory stage has a completed instruction
- M_ready  out  1  stage accepts the instruction this cycle
- M_pc  in  PC_W  instruction PC
- M_isHalt  in  1  instruction is HALT
- M_wen  in  1  instruction writes a register
- M_wreg  in  REG_AW  destination register
- M_wdata  in  DATA_W  result value
- rf_wen  out  1  register file write request
- rf_waddr  out  REG_AW  write index
- rf_wdata  out  DATA_W  write data
- rf_ready  in  1  register file accepts the write this cycle
- W_v  out  1  one instruction retires this cycle
- W_pc  out  PC_W  PC of the retiring instruction
- isHalt  out  1  HALT has retired (sticky)
- fwd_raddr  in  REG_AW  bypass lookup index
- fwd_hit  out  1  a pending queued write to fwd_raddr exists
- fwd_data  out  DATA_W  data of the youngest such write
- occupancy  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset (async, rst_n=0):
  - Queue emptied; pointers and count set to 0.
  - The halt-accepted flag and isHalt cleared.
  - rf_wen, W_v, fwd_hit and occupancy are 0; all data outputs are 0.
  - Reset mid-operation discards all queued entries; no write or retire occurs in that cycle.
- M_ready = !full && !haltAccepted.
- Accept when M_v && M_ready; the entry {pc, isHalt, wen, wreg, wdata} is written at the tail on that posedge.
- While M_ready=0, M_v is ignored and the memory stage must hold its payload.
- Latency: an accepted entry is at the head and eligible to retire no earlier than the next cycle; there is no same-cycle pass-through.
- Head outputs (combinational from the head entry):
  - rf_wen = !empty && head.wen.
  - rf_waddr and rf_wdata = head fields, or 0 when empty.
- Retire condition: !empty && (!head.wen || rf_ready).
  - On retire: W_v=1 and W_pc=head.pc in the same cycle; the head pointer advances at the posedge.
  - At most one retire per cycle.
  - Entries with wen=0 retire without waiting on rf_ready.
- HALT handling:
  - Accepting an entry with M_isHalt sets haltAccepted; M_ready then stays 0 until reset.
  - When the HALT entry retires, W_v=1 (HALT is counted) and isHalt rises at the following posedge.
  - isHalt remains 1 until reset.
  - A HALT with wen=1 is treated as wen=0; HALT never writes the register file.
- Simultaneous accept and retire: both occur and occupancy is unchanged.
  - When full, no accept occurs even if a retire happens that cycle (M_ready depends on the registered count only).
- Full: occupancy == DEPTH.
- Pointers wrap modulo DEPTH; count is tracked separately, so full and empty are unambiguous.
- Forwarding (combinational, queue contents only; the in-flight M_* payload is not searched):
  - Search all valid entries with wen=1 and wreg == fwd_raddr.
  - fwd_hit=1 and fwd_data = the youngest match (nearest the tail).
  - The head entry qualifies even in the cycle it retires.
  - No special case for register 0.
  - No match: fwd_hit=0, fwd_data=0.
- occupancy is registered and reflects the count after the last posedge.

Decomposition:
- Package wb_pkg:
  - DATA_W/REG_AW/PC_W defaults.
  - wb_entry_t packed struct {pc, isHalt, wen, wreg, wdata}.
  - Queue index typedef.
- Sub-module wb_retire_fifo: storage array, head/tail pointers and count.
  - Exposes the head entry, full, empty and the raw entry array with per-entry valid bits.
- The forwarding priority search and halt logic live in wb_retire.

Test Plan:
- Reset, then accept wen=1 r3=0x1234 with rf_ready=1 -> rf_wen=1, r3/0x1234 the cycle after acceptance; W_v=1 with W_pc equal to the PC; occupancy returns to 0.
- rf_ready=0, offer 5 back-to-back writes -> M_ready=0 after 4 accepts, occupancy=4, W_v=0; raise rf_ready -> 4 consecutive W_v pulses in PC order, then the 5th is accepted.
- Queue holds r5=0x0011 (older) and r5=0x0022 (younger) with rf_ready=0; fwd_raddr=5 -> fwd_hit=1, fwd_data=0x0022; fwd_raddr=6 -> fwd_hit=0.
- Entry with wen=0 behind a stalled write -> it retires only after the write retires; it never asserts rf_wen.
- Offer HALT at PC 0x0040 followed by another instruction -> M_ready=0 after HALT is accepted; HALT retires with W_v=1, W_pc=0x0040; isHalt=1 the next cycle and stays high; no rf write.
- Assert rst_n=0 with 3 entries queued and isHalt=1 -> occupancy=0, isHalt=0, rf_wen=0 and W_v=0 immediately; normal acceptance resumes after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback/retire stage.
// Holds the default widths, the queued-entry layout and the queue index type.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_REG_AW = 4;
    localparam int WB_PC_W   = 16;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_PC_W-1:0]   pc;
        logic                 isHalt;
        logic                 wen;
        logic [WB_REG_AW-1:0] wreg;
        logic [WB_DATA_W-1:0] wdata;
    } wb_entry_t;

    typedef logic [$clog2(WB_DEPTH)-1:0] wb_idx_t;

endpackage

// File: rtl/wb_retire_if.sv
// Memory-stage to writeback handshake: M_v/M_ready plus the instruction payload.
// master = memory stage (drives payload), slave = wb_retire (drives M_ready).
interface wb_retire_if
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_AW = WB_REG_AW,
    parameter int PC_W   = WB_PC_W
) ();

    logic              M_v;
    logic              M_ready;
    logic [PC_W-1:0]   M_pc;
    logic              M_isHalt;
    logic              M_wen;
    logic [REG_AW-1:0] M_wreg;
    logic [DATA_W-1:0] M_wdata;

    modport master (
        output M_v, M_pc, M_isHalt, M_wen, M_wreg, M_wdata,
        input  M_ready
    );

    modport slave (
        input  M_v, M_pc, M_isHalt, M_wen, M_wreg, M_wdata,
        output M_ready
    );

endinterface

// File: rtl/wb_retire_fifo.sv
// Retire queue storage: entry array, head/tail pointers and a separate count.
// Ports: push/push_entry, pop -> head_entry, full, empty, count, head_ptr,
// entries (raw array) and valid (per-entry occupancy bits).
module wb_retire_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int IW    = $clog2(DEPTH),
    localparam int CW    = IW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       head_entry,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count,
    output logic [IW-1:0]   head_ptr,
    output wb_entry_t       entries [DEPTH],
    output logic [DEPTH-1:0] valid
);

    wb_entry_t       entries_q [DEPTH];
    wb_entry_t       entries_d [DEPTH];
    logic [IW-1:0]   head_q, head_d;
    logic [IW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (push_ok) begin
            entries_d[tail_q] = push_entry;
            tail_d            = tail_q + IW'(1);
        end
        if (pop_ok) begin
            head_d = head_q + IW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, IW'(i) - head_q} < count_q);
        end
    end

    assign head_entry = entries_q[head_q];
    assign count      = count_q;
    assign head_ptr   = head_q;
    assign entries    = entries_q;

endmodule

// File: rtl/wb_retire.sv
// In-order writeback/retire stage: queues completed instructions, writes the
// register file via rf_wen/rf_ready, pulses W_v per retire, holds sticky isHalt
// and forwards the youngest pending write. Ports: clk, rst_n, m_if (slave),
// rf_*, W_v/W_pc, isHalt, fwd_raddr/fwd_hit/fwd_data, occupancy.
module wb_retire
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_AW = WB_REG_AW,
    parameter int PC_W   = WB_PC_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    wb_retire_if.slave                 m_if,
    output logic                       rf_wen,
    output logic [REG_AW-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    input  logic                       rf_ready,
    output logic                       W_v,
    output logic [PC_W-1:0]            W_pc,
    output logic                       isHalt,
    input  logic [REG_AW-1:0]          fwd_raddr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    wb_entry_t        new_entry;
    wb_entry_t        head_entry;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [IW-1:0]    head_ptr;
    logic             accept;
    logic             retire;
    logic             halt_acc_q, halt_acc_d;
    logic             is_halt_q, is_halt_d;

    assign m_if.M_ready = !full && !halt_acc_q;
    assign accept       = m_if.M_v && m_if.M_ready;

    // A HALT never writes the register file, so its wen is dropped on entry.
    always_comb begin
        new_entry        = '0;
        new_entry.pc     = m_if.M_pc;
        new_entry.isHalt = m_if.M_isHalt;
        new_entry.wen    = m_if.M_wen && !m_if.M_isHalt;
        new_entry.wreg   = m_if.M_wreg;
        new_entry.wdata  = m_if.M_wdata;
    end

    wb_retire_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept),
        .push_entry (new_entry),
        .pop        (retire),
        .head_entry (head_entry),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .head_ptr   (head_ptr),
        .entries    (entries),
        .valid      (valid)
    );

    // Non-writing entries retire without waiting on the register file.
    assign retire   = !empty && (!head_entry.wen || rf_ready);
    assign rf_wen   = !empty && head_entry.wen;
    assign rf_waddr = empty ? '0 : head_entry.wreg;
    assign rf_wdata = empty ? '0 : head_entry.wdata;
    assign W_v      = retire;
    assign W_pc     = retire ? head_entry.pc : '0;

    always_comb begin
        halt_acc_d = halt_acc_q || (accept && m_if.M_isHalt);
        is_halt_d  = is_halt_q || (retire && head_entry.isHalt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_acc_q <= 1'b0;
            is_halt_q  <= 1'b0;
        end else begin
            halt_acc_q <= halt_acc_d;
            is_halt_q  <= is_halt_d;
        end
    end

    assign isHalt    = is_halt_q;
    assign occupancy = count;

    // Walk from head (oldest) to tail (youngest); later matches override.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[head_ptr + IW'(k)] &&
                entries[head_ptr + IW'(k)].wen &&
                entries[head_ptr + IW'(k)].wreg == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[head_ptr + IW'(k)].wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_retire.sv
// Directed self-checking bench for wb_retire.
// Drives at posedge+1, samples at negedge.
module tb_wb_retire;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic        W_v;
    logic [15:0] W_pc;
    logic        isHalt;
    logic [3:0]  fwd_raddr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_retire_if mif ();

    wb_retire dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_if      (mif),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_ready  (rf_ready),
        .W_v       (W_v),
        .W_pc      (W_pc),
        .isHalt    (isHalt),
        .fwd_raddr (fwd_raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [15:0] pc, input logic h,
                         input logic w, input logic [3:0] r,
                         input logic [15:0] d);
        mif.M_v      = 1'b1;
        mif.M_pc     = pc;
        mif.M_isHalt = h;
        mif.M_wen    = w;
        mif.M_wreg   = r;
        mif.M_wdata  = d;
    endtask

    task automatic idle();
        mif.M_v      = 1'b0;
        mif.M_pc     = '0;
        mif.M_isHalt = 1'b0;
        mif.M_wen    = 1'b0;
        mif.M_wreg   = '0;
        mif.M_wdata  = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        rf_ready  = 1'b0;
        fwd_raddr = '0;
        idle();
        #2;
        chk("rst_occ", occupancy, 0);
        chk("rst_rfwen", rf_wen, 0);
        chk("rst_wv", W_v, 0);
        chk("rst_fwd", fwd_hit, 0);
        chk("rst_halt", isHalt, 0);
        chk("rst_wdata", rf_wdata, 0);
        nxt();
        rst_n = 1'b1;

        // single write, no same-cycle pass-through
        nxt();
        offer(16'h0010, 0, 1, 4'd3, 16'h1234);
        rf_ready = 1'b1;
        smp();
        chk("t1_rdy", mif.M_ready, 1);
        chk("t1_nopass", rf_wen, 0);
        nxt();
        idle();
        smp();
        chk("t1_rfwen", rf_wen, 1);
        chk("t1_waddr", rf_waddr, 3);
        chk("t1_wdata", rf_wdata, 16'h1234);
        chk("t1_wv", W_v, 1);
        chk("t1_wpc", W_pc, 16'h0010);
        chk("t1_occ1", occupancy, 1);
        nxt();
        smp();
        chk("t1_occ0", occupancy, 0);
        chk("t1_wv0", W_v, 0);

        // fill under stall, then drain in order
        nxt();
        rf_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(16'h0020 + 16'(i), 0, 1, 4'(i + 1), 16'h0100 + 16'(i));
            smp();
            chk("t2_rdy", mif.M_ready, 1);
            nxt();
        end
        offer(16'h0024, 0, 1, 4'd5, 16'h0104);
        smp();
        chk("t2_full_rdy", mif.M_ready, 0);
        chk("t2_occ4", occupancy, 4);
        chk("t2_wv0", W_v, 0);
        chk("t2_head", rf_waddr, 1);
        nxt();
        rf_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            smp();
            chk("t2_wv", W_v, 1);
            chk("t2_wpc", W_pc, 16'h0020 + 16'(j));
            chk("t2_rdy_d", mif.M_ready, (j != 0) ? 1 : 0);
            nxt();
            if (j == 1) idle();
        end
        smp();
        chk("t2_5th", W_pc, 16'h0024);
        nxt();
        smp();
        chk("t2_occ0", occupancy, 0);

        // forwarding picks the youngest match
        nxt();
        rf_ready = 1'b0;
        offer(16'h0030, 0, 1, 4'd5, 16'h0011);
        nxt();
        offer(16'h0031, 0, 1, 4'd5, 16'h0022);
        nxt();
        idle();
        fwd_raddr = 4'd5;
        smp();
        chk("t3_hit", fwd_hit, 1);
        chk("t3_data", fwd_data, 16'h0022);
        chk("t3_occ", occupancy, 2);
        fwd_raddr = 4'd6;
        #1;
        chk("t3_miss", fwd_hit, 0);
        chk("t3_mdata", fwd_data, 0);

        // non-writing entry waits behind a stalled write
        nxt();
        offer(16'h0032, 0, 0, 4'd7, 16'h0777);
        smp();
        chk("t4_wv0", W_v, 0);
        chk("t4_rfwen", rf_wen, 1);
        chk("t4_waddr", rf_waddr, 5);
        nxt();
        idle();
        rf_ready = 1'b1;
        smp();
        chk("t4_pc30", W_pc, 16'h0030);
        nxt();
        smp();
        chk("t4_pc31", W_pc, 16'h0031);
        nxt();
        rf_ready = 1'b0;
        smp();
        chk("t4_wv32", W_v, 1);
        chk("t4_pc32", W_pc, 16'h0032);
        chk("t4_norf", rf_wen, 0);
        nxt();
        smp();
        chk("t4_occ0", occupancy, 0);

        // HALT: blocks acceptance, retires without a write, sticky isHalt
        nxt();
        rf_ready = 1'b1;
        offer(16'h0040, 1, 1, 4'd9, 16'hdead);
        smp();
        chk("t5_rdy", mif.M_ready, 1);
        nxt();
        offer(16'h0041, 0, 1, 4'd2, 16'h0055);
        smp();
        chk("t5_rdy0", mif.M_ready, 0);
        chk("t5_wv", W_v, 1);
        chk("t5_wpc", W_pc, 16'h0040);
        chk("t5_norf", rf_wen, 0);
        chk("t5_halt0", isHalt, 0);
        chk("t5_occ1", occupancy, 1);
        nxt();
        smp();
        chk("t5_halt1", isHalt, 1);
        chk("t5_occ0", occupancy, 0);
        chk("t5_wv0", W_v, 0);
        repeat (3) nxt();
        smp();
        chk("t5_sticky", isHalt, 1);
        chk("t5_blocked", occupancy, 0);
        idle();

        // async reset clears halt, then discards a loaded queue
        nxt();
        rst_n = 1'b0;
        #1;
        chk("t6_halt_clr", isHalt, 0);
        chk("t6_rdy", mif.M_ready, 1);
        nxt();
        rst_n    = 1'b1;
        rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(16'h0050 + 16'(i), 0, 1, 4'(i + 10), 16'h0200 + 16'(i));
            nxt();
        end
        idle();
        smp();
        chk("t6_occ3", occupancy, 3);
        chk("t6_rfwen1", rf_wen, 1);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("t6_occ0", occupancy, 0);
        chk("t6_rfwen0", rf_wen, 0);
        chk("t6_wv0", W_v, 0);
        nxt();
        rst_n    = 1'b1;
        rf_ready = 1'b1;
        offer(16'h0060, 0, 1, 4'd8, 16'habcd);
        nxt();
        idle();
        smp();
        chk("t6_wv", W_v, 1);
        chk("t6_wpc", W_pc, 16'h0060);
        chk("t6_waddr", rf_waddr, 8);
        chk("t6_wdata", rf_wdata, 16'habcd);
        nxt();
        smp();
        chk("t6_end_occ", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
